vec_writeback: RTL and testbench
================================

# vec_writeback

Vector writeback/merge unit that drives the write side of the vector register file. It accepts one completed result per transaction from the execute stage and reads the current destination group and the v0 mask from the register file. It merges active, inactive (masked-off) and tail elements according to RISC-V vm/vta/vma policy, then issues a single write (`rf_wr_en` or `rf_mask_wr_en`).

## Interface
- `VLEN`, 512: bits per vector register.
- `DATA_WIDTH`, 8*VLEN: widest register group (LMUL=8).
- `ADDR_WIDTH`, 5: register address width (32 registers).
- `VL_WIDTH`, $clog2(VLEN)+1: width of vl.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: reset, asynchronous, active-low.
- `res_valid` in 1: result available.
- `res_ready` out 1: unit can accept a result.
- `res_data` in DATA_WIDTH: raw result, element i at bits [i*EW +: EW].
- `res_vd` in ADDR_WIDTH: destination base register.
- `res_lmul` in 4: one-hot LMUL (0001/0010/0100/1000).
- `res_sew` in 2: 0=8, 1=16, 2=32, 3=64 bits (EW = 8<<sew).
- `res_vl` in VL_WIDTH: element count.
- `res_vm` in 1: 1 = unmasked.
- `res_vta`, `res_vma` in 1: tail/mask agnostic.
- `res_mask_op` in 1: result is a mask (1 bit per element, single register).
- `rf_waddr` out ADDR_WIDTH: write/destination-read address.
- `rf_lmul` out 4: LMUL to regfile.
- `rf_mask_operation` out 1: mask-op indicator to regfile.
- `rf_wdata` out DATA_WIDTH: merged write data.
- `rf_wr_en` out 1: group write strobe.
- `rf_mask_wr_en` out 1: v0 write strobe.
- `rf_dst_data` in DATA_WIDTH: current destination group (combinational from rf_waddr/rf_lmul).
- `rf_v0_mask` in VLEN: contents of v0.
- `wb_done` out 1: one-cycle pulse, transaction finished.
- `wb_error` out 1: one-cycle pulse with wb_done, write suppressed.

## Operation
- FSM: IDLE -> FETCH -> MERGE -> WRITE -> IDLE.
- IDLE: `res_ready`=1. On `res_valid`&&`res_ready`, latch all res_* fields and go to FETCH.
- Legality check on latched fields. Each of the following is an error:
  - lmul not one-hot;
  - res_vd % LMUL != 0;
  - res_vd + LMUL > 32;
  - res_vl > VLMAX, where VLMAX = LMUL*VLEN/EW (mask op: VLEN);
  - res_vm=0 && res_vd==0 && !res_mask_op.
- FETCH:
  - Drive `rf_waddr`=vd.
  - Drive `rf_lmul`=lmul (0001 when mask op).
  - Drive `rf_mask_operation`=mask_op.
  - Register `rf_dst_data` and `rf_v0_mask` at the end of the cycle.
  - Address outputs hold through WRITE.
- MERGE: compute and register `rf_wdata`.
  - Vector op, element i < VLMAX:
    - i >= vl: tail. All-ones if vta, else dst.
    - i < vl, vm=0, v0[i]=0: inactive. All-ones if vma, else dst.
    - Otherwise active: res_data element.
  - Bits above VLMAX*EW = 0.
  - Mask op: bit-granular over VLEN bits. Bits >= vl are always 1 (tail-agnostic). Inactive bits take dst bit (vma ignored). Bits above VLEN = 0.
- WRITE (one cycle):
  - Legal, mask op, vd==0: `rf_mask_wr_en`=1.
  - Legal, otherwise: `rf_wr_en`=1.
  - Error: neither strobe; `wb_error`=1.
  - `wb_done`=1 in all cases. Next state IDLE.
- vl=0: every element is tail; a write is still issued.

## Timing
- Reset values (asynchronous, and whenever reset is low):
  - state IDLE, `res_ready`=1.
  - All other outputs 0; latched fields 0.
- Accept at edge 0. FETCH is cycle 1, MERGE cycle 2, WRITE cycle 3. `res_ready` is high again in cycle 4.
- Throughput: one transaction per 4 cycles.
- Write strobes are high from posedge to posedge; the regfile commits on the falling edge within that cycle.
- `res_ready` is low in FETCH/MERGE/WRITE. `res_valid` during those states is ignored, and must be held by the producer.
- Reset mid-transaction discards it: no strobe, no done.
- Strobes never assert outside WRITE. `wb_done` and `wb_error` are never high in consecutive cycles.

## Test plan
- LMUL=1, SEW=32, vd=4, vl=16, vm=1, res_data element i = i -> `rf_wr_en` in cycle 3 with waddr=4 and wdata elements 0..15 = 0..15; `wb_done`=1, `wb_error`=0.
- LMUL=1, SEW=8, vd=2, vl=8, vm=0, v0=0x55, vma=0, vta=1, dst bytes 0xAA -> bytes 0,2,4,6 = result, bytes 1,3,5,7 = 0xAA, bytes 8..63 = 0xFF.
- LMUL=2, vd=3 -> no strobe; `wb_done` and `wb_error` pulse in cycle 3. LMUL=4, vd=28, SEW=32, vl=64 -> `rf_wr_en` with waddr=28.
- Mask op, vd=0, vl=10, vm=1, result bits 0x3FF -> `rf_mask_wr_en`=1, `rf_wr_en`=0, wdata[9:0]=0x3FF, bits 10..511=1.
- Two back-to-back requests, second `res_valid` held from cycle 1 -> second accepted at cycle 4 edge; writes in cycles 3 and 7.
- Reset low during MERGE -> outputs 0, `res_ready`=1, no write or done after release.

Source files
------------

// File: rtl/vec_writeback.sv
// Vector writeback/merge unit: latches one execute result, fetches the destination
// group and v0, merges active/inactive/tail elements, then issues a single regfile write.
module vec_writeback #(
   parameter int VLEN       = 512,
   parameter int DATA_WIDTH = 8*VLEN,
   parameter int ADDR_WIDTH = 5,
   parameter int VL_WIDTH   = $clog2(VLEN)+1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [DATA_WIDTH-1:0] res_data,
   input  logic [ADDR_WIDTH-1:0] res_vd,
   input  logic [3:0]            res_lmul,
   input  logic [1:0]            res_sew,
   input  logic [VL_WIDTH-1:0]   res_vl,
   input  logic                  res_vm,
   input  logic                  res_vta,
   input  logic                  res_vma,
   input  logic                  res_mask_op,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [3:0]            rf_lmul,
   output logic                  rf_mask_operation,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  rf_wr_en,
   output logic                  rf_mask_wr_en,
   input  logic [DATA_WIDTH-1:0] rf_dst_data,
   input  logic [VLEN-1:0]       rf_v0_mask,
   output logic                  wb_done,
   output logic                  wb_error
);

   typedef enum logic [1:0] {IDLE, FETCH, MERGE, WRITE} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   data_p0;
   logic [ADDR_WIDTH-1:0]   vd_p0;
   logic [3:0]              lmul_p0;
   logic [1:0]              sew_p0;
   logic [VL_WIDTH-1:0]     vl_p0;
   logic                    vm_p0, vta_p0, vma_p0, mask_op_p0;
   logic [DATA_WIDTH-1:0]   dst_p1;
   logic [VLEN-1:0]         v0_p1;

   int                      lmul_n;
   int                      eff_lmul;
   int                      vlmax;
   logic                    illegal;

   // Bit-granular merge; element index of bit b is b >> log2(EW).
   function automatic logic [DATA_WIDTH-1:0] merge_data(
      input logic [DATA_WIDTH-1:0] res,
      input logic [DATA_WIDTH-1:0] dst,
      input logic [VLEN-1:0]       v0,
      input logic [1:0]            sew,
      input int                    lmul_cnt,
      input int                    vl,
      input logic                  vm,
      input logic                  vta,
      input logic                  vma,
      input logic                  mask_op
   );
      logic [DATA_WIDTH-1:0] merged;
      int                    eidx;
      int                    group_bits;
      merged     = '0;
      group_bits = lmul_cnt * VLEN;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         eidx = b >> (3 + int'(sew));
         if (mask_op) begin
            if (b < VLEN) begin
               if (b >= vl)
                  merged[b] = 1'b1;
               else if (!vm && !v0[b])
                  merged[b] = dst[b];
               else
                  merged[b] = res[b];
            end
         end else if (b < group_bits) begin
            if (eidx >= vl)
               merged[b] = vta ? 1'b1 : dst[b];
            else if (!vm && !v0[eidx])
               merged[b] = vma ? 1'b1 : dst[b];
            else
               merged[b] = res[b];
         end
      end
      return merged;
   endfunction

   // A mask result always occupies a single register, so alignment uses LMUL=1.
   always_comb begin
      lmul_n = 0;
      case (lmul_p0)
         4'b0001: lmul_n = 1;
         4'b0010: lmul_n = 2;
         4'b0100: lmul_n = 4;
         4'b1000: lmul_n = 8;
         default: lmul_n = 0;
      endcase
      eff_lmul = mask_op_p0 ? 1 : lmul_n;
      vlmax    = mask_op_p0 ? VLEN : ((lmul_n * VLEN) >> (3 + int'(sew_p0)));
      illegal  = (lmul_n == 0)
              || ((int'(vd_p0) & (eff_lmul - 1)) != 0)
              || ((int'(vd_p0) + eff_lmul) > (1 << ADDR_WIDTH))
              || (int'(vl_p0) > vlmax)
              || (!vm_p0 && (vd_p0 == '0) && !mask_op_p0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         res_ready         <= 1'b1;
         rf_waddr          <= '0;
         rf_lmul           <= '0;
         rf_mask_operation <= 1'b0;
         rf_wdata          <= '0;
         rf_wr_en          <= 1'b0;
         rf_mask_wr_en     <= 1'b0;
         wb_done           <= 1'b0;
         wb_error          <= 1'b0;
         data_p0           <= '0;
         vd_p0             <= '0;
         lmul_p0           <= '0;
         sew_p0            <= '0;
         vl_p0             <= '0;
         vm_p0             <= 1'b0;
         vta_p0            <= 1'b0;
         vma_p0            <= 1'b0;
         mask_op_p0        <= 1'b0;
         dst_p1            <= '0;
         v0_p1             <= '0;
      end else begin
         rf_wr_en      <= 1'b0;
         rf_mask_wr_en <= 1'b0;
         wb_done       <= 1'b0;
         wb_error      <= 1'b0;
         case (state)
            IDLE: begin
               if (res_valid && res_ready) begin
                  data_p0           <= res_data;
                  vd_p0             <= res_vd;
                  lmul_p0           <= res_lmul;
                  sew_p0            <= res_sew;
                  vl_p0             <= res_vl;
                  vm_p0             <= res_vm;
                  vta_p0            <= res_vta;
                  vma_p0            <= res_vma;
                  mask_op_p0        <= res_mask_op;
                  rf_waddr          <= res_vd;
                  rf_lmul           <= res_mask_op ? 4'b0001 : res_lmul;
                  rf_mask_operation <= res_mask_op;
                  res_ready         <= 1'b0;
                  state             <= FETCH;
               end
            end
            // p0 -> p1: capture destination group and v0 addressed during FETCH
            FETCH: begin
               dst_p1 <= rf_dst_data;
               v0_p1  <= rf_v0_mask;
               state  <= MERGE;
            end
            // p1 -> write: merged data and strobes become visible together
            MERGE: begin
               rf_wdata <= merge_data(data_p0, dst_p1, v0_p1, sew_p0, lmul_n,
                                      int'(vl_p0), vm_p0, vta_p0, vma_p0, mask_op_p0);
               if (illegal)
                  wb_error <= 1'b1;
               else if (mask_op_p0 && (vd_p0 == '0))
                  rf_mask_wr_en <= 1'b1;
               else
                  rf_wr_en <= 1'b1;
               wb_done <= 1'b1;
               state   <= WRITE;
            end
            WRITE: begin
               res_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               res_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_writeback.sv
// Bench for vec_writeback: vector table driven through a scoreboard queue, plus
// back-to-back and mid-transaction reset sequences.
module tb_vec_writeback;
   localparam int VLEN = 512;
   localparam int DW   = 8*VLEN;
   localparam int AW   = 5;
   localparam int VLW  = $clog2(VLEN)+1;
   localparam int NV   = 14;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            res_valid;
   logic            res_ready;
   logic [DW-1:0]   res_data;
   logic [AW-1:0]   res_vd;
   logic [3:0]      res_lmul;
   logic [1:0]      res_sew;
   logic [VLW-1:0]  res_vl;
   logic            res_vm, res_vta, res_vma, res_mask_op;
   logic [AW-1:0]   rf_waddr;
   logic [3:0]      rf_lmul;
   logic            rf_mask_operation;
   logic [DW-1:0]   rf_wdata;
   logic            rf_wr_en, rf_mask_wr_en;
   logic [DW-1:0]   rf_dst_data;
   logic [VLEN-1:0] rf_v0_mask;
   logic            wb_done, wb_error;

   always #5 clk = ~clk;

   vec_writeback #(.VLEN(VLEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VLW)) dut (
      .clk(clk), .reset(reset),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_vd(res_vd), .res_lmul(res_lmul), .res_sew(res_sew), .res_vl(res_vl),
      .res_vm(res_vm), .res_vta(res_vta), .res_vma(res_vma), .res_mask_op(res_mask_op),
      .rf_waddr(rf_waddr), .rf_lmul(rf_lmul), .rf_mask_operation(rf_mask_operation),
      .rf_wdata(rf_wdata), .rf_wr_en(rf_wr_en), .rf_mask_wr_en(rf_mask_wr_en),
      .rf_dst_data(rf_dst_data), .rf_v0_mask(rf_v0_mask),
      .wb_done(wb_done), .wb_error(wb_error)
   );

   typedef struct packed {
      logic [4:0]  vd;
      logic [3:0]  lmul;
      logic [1:0]  sew;
      logic [9:0]  vl;
      logic        vm, vta, vma, mop;
      logic [1:0]  dmode;
      logic [7:0]  dfill;
      logic [63:0] v0lo;
      logic        err, mwr;
   } vec_t;

   typedef struct {
      logic [DW-1:0] wdata;
      logic [AW-1:0] waddr;
      logic [3:0]    lmul;
      logic          mop, wr, mwr, err;
      int            acc;
      int            id;
   } exp_t;

   exp_t          q[$];
   vec_t          tbl[NV];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   logic          prev_done = 1'b0;
   logic [DW-1:0] last_wdata = '0;

   task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec%0d: got %0h expected %0h", name, id, act, exp);
      end
   endtask

   task automatic chk_wide(input string name, input int id, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      int k;
      total++;
      if (act !== exp) begin
         bad++;
         k = 0;
         while (k < DW/64-1 && act[k*64 +: 64] === exp[k*64 +: 64]) k++;
         $display("FAIL %s vec%0d: word%0d got %h expected %h", name, id, k, act[k*64 +: 64], exp[k*64 +: 64]);
      end
   endtask

   function automatic vec_t mk(input int vd, input int lmul, input int sew, input int vl,
                               input bit vm, input bit vta, input bit vma, input bit mop,
                               input int dmode, input int dfill, input logic [63:0] v0lo,
                               input bit err, input bit mwr);
      vec_t r;
      r.vd = 5'(vd);   r.lmul = 4'(lmul); r.sew = 2'(sew);  r.vl = 10'(vl);
      r.vm = vm;       r.vta = vta;       r.vma = vma;      r.mop = mop;
      r.dmode = 2'(dmode); r.dfill = 8'(dfill); r.v0lo = v0lo;
      r.err = err;     r.mwr = mwr;
      return r;
   endfunction

   // Reference merge, walked element by element.
   function automatic logic [DW-1:0] model(input vec_t r, input logic [DW-1:0] res,
                                           input logic [DW-1:0] dst, input logic [VLEN-1:0] v0);
      logic [DW-1:0] o;
      int ew, nl, vmax, b;
      o = '0;
      if (r.mop) begin
         for (int k = 0; k < VLEN; k++)
            o[k] = (k >= int'(r.vl)) ? 1'b1 : ((!r.vm && !v0[k]) ? dst[k] : res[k]);
      end else begin
         ew = 8 << r.sew;
         case (r.lmul)
            4'd1: nl = 1;
            4'd2: nl = 2;
            4'd4: nl = 4;
            4'd8: nl = 8;
            default: nl = 0;
         endcase
         vmax = nl * VLEN / ew;
         for (int i = 0; i < vmax; i++)
            for (int j = 0; j < ew; j++) begin
               b = i*ew + j;
               if (i >= int'(r.vl))            o[b] = r.vta ? 1'b1 : dst[b];
               else if (!r.vm && !v0[i])       o[b] = r.vma ? 1'b1 : dst[b];
               else                            o[b] = res[b];
            end
      end
      return o;
   endfunction

   task automatic prep_rf(input vec_t r);
      for (int w = 0; w < DW/32; w++)
         rf_dst_data[w*32 +: 32] = (r.dfill != 8'h0) ? {4{r.dfill}} : $urandom;
      for (int w = 0; w < VLEN/32; w++)
         rf_v0_mask[w*32 +: 32] = $urandom;
      rf_v0_mask[63:0] = r.v0lo;
   endtask

   task automatic prep_res(input vec_t r);
      for (int w = 0; w < DW/32; w++)
         res_data[w*32 +: 32] = (r.dmode == 2'd1) ? 32'(w) : $urandom;
      if (r.dmode == 2'd2) res_data[9:0] = 10'h3FF;
   endtask

   task automatic send(input vec_t r, input int id, output int acc);
      exp_t e;
      int   n;
      res_vd = r.vd;   res_lmul = r.lmul; res_sew = r.sew; res_vl = r.vl;
      res_vm = r.vm;   res_vta = r.vta;   res_vma = r.vma; res_mask_op = r.mop;
      res_valid = 1'b1;
      n = 0;
      while (!res_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_wait", id, 64'(res_ready), 64'(1));
      @(posedge clk);
      #1;
      acc     = cyc;
      e.wdata = model(r, res_data, rf_dst_data, rf_v0_mask);
      e.waddr = r.vd;
      e.lmul  = r.mop ? 4'b0001 : r.lmul;
      e.mop   = r.mop;
      e.err   = r.err;
      e.mwr   = !r.err && r.mwr;
      e.wr    = !r.err && !r.mwr;
      e.acc   = acc;
      e.id    = id;
      q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 40) begin @(negedge clk); n++; end
      chk("drain_pending", -1, 64'(q.size()), 64'(0));
      q.delete();
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_ready"}, -1, 64'(res_ready), 64'(1));
      chk({name, "_wr_en"}, -1, 64'(rf_wr_en), 64'(0));
      chk({name, "_mask_wr_en"}, -1, 64'(rf_mask_wr_en), 64'(0));
      chk({name, "_done"}, -1, 64'(wb_done), 64'(0));
      chk({name, "_error"}, -1, 64'(wb_error), 64'(0));
      chk({name, "_waddr"}, -1, 64'(rf_waddr), 64'(0));
      chk({name, "_lmul"}, -1, 64'(rf_lmul), 64'(0));
      chk({name, "_mask_op"}, -1, 64'(rf_mask_operation), 64'(0));
      chk({name, "_wdata_any"}, -1, 64'(|rf_wdata), 64'(0));
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         chk("strobe_scope", -1, 64'((rf_wr_en || rf_mask_wr_en || wb_error) && !wb_done), 64'(0));
         chk("done_gap", -1, 64'(prev_done && wb_done), 64'(0));
         if (wb_done) begin
            done_cnt++;
            last_wdata = rf_wdata;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got wb_done=1 expected none pending");
            end else begin
               e = q.pop_front();
               chk("done_cycle", e.id, 64'(cyc - e.acc), 64'(2));
               chk("wr_en", e.id, 64'(rf_wr_en), 64'(e.wr));
               chk("mask_wr_en", e.id, 64'(rf_mask_wr_en), 64'(e.mwr));
               chk("wb_error", e.id, 64'(wb_error), 64'(e.err));
               chk("waddr", e.id, 64'(rf_waddr), 64'(e.waddr));
               chk("rf_lmul", e.id, 64'(rf_lmul), 64'(e.lmul));
               chk("mask_operation", e.id, 64'(rf_mask_operation), 64'(e.mop));
               if (!e.err) chk_wide("wdata", e.id, rf_wdata, e.wdata);
            end
         end
         prev_done = wb_done;
      end else begin
         prev_done = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, d0;
      res_valid = 1'b0; res_data = '0; res_vd = '0; res_lmul = '0; res_sew = '0;
      res_vl = '0; res_vm = 1'b0; res_vta = 1'b0; res_vma = 1'b0; res_mask_op = 1'b0;
      rf_dst_data = '0; rf_v0_mask = '0;

      //            vd lmul sew vl   vm vta vma mop dm fill  v0lo                    err mwr
      tbl[0]  = mk(4,  1,   2,  16,  1, 0,  0,  0,  1, 0,    64'h0,                  0,  0);
      tbl[1]  = mk(2,  1,   0,  8,   0, 1,  0,  0,  0, 8'hAA, 64'h55,                0,  0);
      tbl[2]  = mk(3,  2,   2,  16,  1, 0,  0,  0,  0, 0,    64'h0,                  1,  0);
      tbl[3]  = mk(28, 4,   2,  64,  1, 0,  0,  0,  0, 0,    64'h0,                  0,  0);
      tbl[4]  = mk(0,  1,   0,  10,  1, 0,  0,  1,  2, 0,    64'h0,                  0,  1);
      tbl[5]  = mk(8,  8,   3,  0,   1, 0,  0,  0,  0, 0,    64'h0,                  0,  0);
      tbl[6]  = mk(6,  1,   3,  9,   1, 0,  0,  0,  0, 0,    64'h0,                  1,  0);
      tbl[7]  = mk(0,  1,   2,  4,   0, 0,  0,  0,  0, 0,    64'hF,                  1,  0);
      tbl[8]  = mk(4,  3,   2,  4,   1, 0,  0,  0,  0, 0,    64'h0,                  1,  0);
      tbl[9]  = mk(30, 4,   0,  10,  1, 0,  0,  0,  0, 0,    64'h0,                  1,  0);
      tbl[10] = mk(10, 2,   1,  40,  0, 0,  1,  0,  0, 0,    64'hDEAD_BEEF_0F0F_5A5A, 0,  0);
      tbl[11] = mk(5,  1,   0,  100, 0, 1,  1,  1,  0, 0,    64'hF0F0_1234_5678_9ABC, 0,  0);
      tbl[12] = mk(0,  8,   0,  512, 1, 0,  0,  0,  0, 0,    64'h0,                  0,  0);
      tbl[13] = mk(0,  1,   0,  20,  0, 0,  1,  1,  0, 0,    64'hA5A5_3C3C_C3C3_5A5A, 0,  1);

      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         prep_rf(tbl[i]);
         prep_res(tbl[i]);
         send(tbl[i], i, a1);
         res_valid = 1'b0;
         drain();
         if (i == 0)
            for (int e = 0; e < 16; e++)
               chk("t1_elem", i, 64'(last_wdata[e*32 +: 32]), 64'(e));
         if (i == 1) begin
            for (int k = 0; k < 8; k++)
               chk("t2_byte", i, 64'(last_wdata[k*8 +: 8]),
                   (k % 2 == 0) ? 64'(res_data[k*8 +: 8]) : 64'hAA);
            chk("t2_tail_ones", i, 64'(&last_wdata[VLEN-1:64]), 64'(1));
            chk("t2_above_group", i, 64'(|last_wdata[DW-1:VLEN]), 64'(0));
         end
         if (i == 4) begin
            chk("mask_low", i, 64'(last_wdata[9:0]), 64'h3FF);
            chk("mask_tail_ones", i, 64'(&last_wdata[VLEN-1:10]), 64'(1));
            chk("mask_above_vlen", i, 64'(|last_wdata[DW-1:VLEN]), 64'(0));
         end
      end

      // Back-to-back with valid held through the busy cycles.
      prep_rf(tbl[3]);
      prep_res(tbl[3]);
      send(tbl[3], 100, a1);
      prep_res(tbl[10]);
      send(tbl[10], 101, a2);
      res_valid = 1'b0;
      chk("b2b_accept_gap", 101, 64'(a2 - a1), 64'(4));
      drain();

      // Reset asserted during MERGE discards the transaction.
      prep_rf(tbl[0]);
      prep_res(tbl[0]);
      send(tbl[0], 200, a1);
      res_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      q.delete();
      d0 = done_cnt;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("midreset_no_done", 200, 64'(done_cnt - d0), 64'(0));
      chk("midreset_ready", 200, 64'(res_ready), 64'(1));

      prep_rf(tbl[1]);
      prep_res(tbl[1]);
      send(tbl[1], 201, a1);
      res_valid = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
